// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexed 4-digit BCD scanner with per-slot blanking and frame-synchronous loads
module bcd_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        LZBlank,
  input  logic        LoadValid,
  input  logic [15:0] LoadValue,
  output logic        LoadReady,
  output logic [3:0]  BCDOut,
  output logic        DigitBlank,
  output logic [3:0]  DigitEnable,
  output logic        FrameStart
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d, run_q, lzb_q;
  logic [3:0] digit;
  logic lz, dark, wrap, commit, accept, go;
  // Outputs depend only on registers; run_q and lzb_q are registered copies of Enable and LZBlank
  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
    lz = lzb_q && (idx_q == 2'd3 ? disp_q[15:12] == 4'h0 :
                   idx_q == 2'd2 ? disp_q[15:8] == 8'h00 :
                   idx_q == 2'd1 ? disp_q[15:4] == 12'h000 : 1'b0);
    dark = !run_q || state_q == BLANK;
    BCDOut = digit;
    DigitBlank = dark || digit > 4'd9 || lz;
    DigitEnable = dark ? 4'hF : ~(4'b0001 << idx_q);
    FrameStart = run_q && cnt_q == '0 && idx_q == 2'd0;
    LoadReady = !pend_v_q;
  end
  // The first enabled edge only arms run_q, so the counter sits at 0 for one cycle to emit FrameStart
  always_comb begin
    go = Enable && run_q;
    wrap = cnt_q == CNT_LAST;
    cnt_d = go ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    idx_d = go ? (wrap ? idx_q + 2'd1 : idx_q) : 2'd0;
    state_d = cnt_d < BLANK_END ? BLANK : DRIVE;
    commit = FrameStart && pend_v_q;
    accept = LoadValid && LoadReady;
    disp_d = commit ? pend_q : disp_q;
    pend_d = accept ? LoadValue : pend_q;
    pend_v_d = accept || (pend_v_q && !commit);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= BLANK;
      cnt_q <= '0;
      idx_q <= 2'd0;
      disp_q <= 16'h0000;
      pend_q <= 16'h0000;
      pend_v_q <= 1'b0;
      run_q <= 1'b0;
      lzb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      run_q <= Enable;
      lzb_q <= LZBlank;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: time-based reference model plus directed and random stimulus
module tb_bcd_display_scanner;
  logic Clock = 1'b0, Reset, Enable, LZBlank, LoadValid;
  logic [15:0] LoadValue;
  logic LoadReady, DigitBlank, FrameStart;
  logic [3:0] BCDOut, DigitEnable;
  int n_chk = 0, n_fail = 0;

  bcd_display_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .LZBlank(LZBlank),
    .LoadValid(LoadValid), .LoadValue(LoadValue), .LoadReady(LoadReady),
    .BCDOut(BCDOut), .DigitBlank(DigitBlank), .DigitEnable(DigitEnable),
    .FrameStart(FrameStart)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts enabled cycles since the scan (re)started; slot = m_t/8, digit = slot%4
  int m_t = 0;
  logic m_run = 1'b0, m_pv = 1'b0, m_lz = 1'b0;
  logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_t <= 0; m_run <= 1'b0; m_pv <= 1'b0; m_lz <= 1'b0; m_disp <= 16'h0; m_pend <= 16'h0;
    end else begin
      if (m_run && m_t % 32 == 0 && m_pv) begin
        m_disp <= m_pend;
        m_pv <= 1'b0;
      end else if (LoadValid && !m_pv) begin
        m_pend <= LoadValue;
        m_pv <= 1'b1;
      end
      m_t <= (Enable && m_run) ? m_t + 1 : 0;
      m_run <= Enable;
      m_lz <= LZBlank;
    end
  end

  int e_idx;
  logic e_dark, e_lz;
  logic [3:0] e_dig, e_den;
  always @(negedge Clock) begin
    e_idx = (m_t / 8) % 4;
    e_dark = !m_run || (m_t % 8) < 2;
    e_dig = m_disp[e_idx*4 +: 4];
    e_lz = m_lz && e_idx > 0 && (m_disp >> (4 * e_idx)) == 16'h0;
    e_den = e_dark ? 4'hF : ~(4'b0001 << e_idx);
    check("m_frame_start", {15'h0, FrameStart}, {15'h0, m_run && m_t % 32 == 0});
    check("m_load_ready", {15'h0, LoadReady}, {15'h0, !m_pv});
    check("m_bcd_out", {12'h0, BCDOut}, {12'h0, e_dig});
    check("m_digit_en", {12'h0, DigitEnable}, {12'h0, e_den});
    check("m_digit_blank", {15'h0, DigitBlank}, {15'h0, e_dark || e_dig > 4'd9 || e_lz});
  end

  task automatic wait_fs();
    int k = 0;
    while (FrameStart !== 1'b1 && k < 64) begin
      @(negedge Clock);
      k++;
    end
    if (FrameStart !== 1'b1) check("wait_fs_timeout", {15'h0, FrameStart}, 16'h1);
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge Clock);
    check("ready_before_load", {15'h0, LoadReady}, 16'h1);
    LoadValid = 1'b1;
    LoadValue = v;
    @(negedge Clock);
    LoadValid = 1'b0;
    check("ready_after_load", {15'h0, LoadReady}, 16'h0);
  endtask

  task automatic run_frame(input logic [15:0] bcd, input logic [3:0] blk);
    logic [3:0] den;
    wait_fs();
    for (int i = 1; i < 32; i++) begin
      @(negedge Clock);
      if (i == 1) check("ready_after_commit", {15'h0, LoadReady}, 16'h1);
      if (i % 8 == 1) check("slot_dark", {12'h0, DigitEnable}, 16'h000F);
      if (i % 8 == 5) begin
        den = ~(4'b0001 << (i / 8));
        check("slot_bcd", {12'h0, BCDOut}, {12'h0, bcd[(i/8)*4 +: 4]});
        check("slot_enable", {12'h0, DigitEnable}, {12'h0, den});
        check("slot_blank", {15'h0, DigitBlank}, {15'h0, blk[i/8]});
      end
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int d = 0; d < 4; d++)
      v[d*4 +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 11));
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Enable = 1'b1; LZBlank = 1'b0; LoadValid = 1'b0; LoadValue = 16'h0;
    repeat (2) @(negedge Clock);
    check("rst_ready", {15'h0, LoadReady}, 16'h1);
    check("rst_fs", {15'h0, FrameStart}, 16'h0);
    check("rst_bcd", {12'h0, BCDOut}, 16'h0);
    check("rst_blank", {15'h0, DigitBlank}, 16'h1);
    check("rst_enable", {12'h0, DigitEnable}, 16'h000F);
    #2 Reset = 1'b0;
    @(negedge Clock);
    check("first_fs", {15'h0, FrameStart}, 16'h1);
    load(16'h1234);
    run_frame(16'h1234, 4'b0000);
    LZBlank = 1'b1;
    load(16'h0045);
    run_frame(16'h0045, 4'b1100);
    LZBlank = 1'b0;
    load(16'h0045);
    run_frame(16'h0045, 4'b0000);
    LZBlank = 1'b1;
    load(16'h0000);
    run_frame(16'h0000, 4'b1110);
    load(16'hA000);
    run_frame(16'hA000, 4'b1000);
    LZBlank = 1'b0;
    load(16'h1111);
    wait_fs();
    check("coincide_ready_low", {15'h0, LoadReady}, 16'h0);
    LoadValid = 1'b1;
    LoadValue = 16'h2222;
    @(negedge Clock);
    check("coincide_ready_rise", {15'h0, LoadReady}, 16'h1);
    @(negedge Clock);
    LoadValid = 1'b0;
    check("coincide_accepted", {15'h0, LoadReady}, 16'h0);
    check("coincide_old_shown", {12'h0, BCDOut}, 16'h1);
    run_frame(16'h2222, 4'b0000);
    load(16'h9999);
    run_frame(16'h9999, 4'b0000);
    load(16'h8888);
    repeat (19) @(negedge Clock);
    check("pre_reset_bcd", {12'h0, BCDOut}, 16'h9);
    check("pre_reset_enable", {12'h0, DigitEnable}, 16'h000B);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_enable", {12'h0, DigitEnable}, 16'h000F);
    check("async_rst_blank", {15'h0, DigitBlank}, 16'h1);
    check("async_rst_bcd", {12'h0, BCDOut}, 16'h0);
    check("async_rst_ready", {15'h0, LoadReady}, 16'h1);
    @(negedge Clock);
    #2 Reset = 1'b0;
    run_frame(16'h0000, 4'b0000);
    repeat (11) @(negedge Clock);
    check("digit1_enable", {12'h0, DigitEnable}, 16'h000D);
    Enable = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      check("disabled_dark", {12'h0, DigitEnable}, 16'h000F);
    end
    Enable = 1'b1;
    @(negedge Clock);
    check("reenable_fs", {15'h0, FrameStart}, 16'h1);
    repeat (2) @(negedge Clock);
    check("reenable_digit0", {12'h0, DigitEnable}, 16'h000E);
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      LoadValid = $urandom_range(0, 9) == 0;
      LoadValue = rand_bcd();
      if ($urandom_range(0, 99) == 0) LZBlank = ~LZBlank;
      if (Enable ? $urandom_range(0, 59) == 0 : $urandom_range(0, 4) == 0) Enable = ~Enable;
      if (Reset) #2 Reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) #2 Reset = 1'b1;
    end
    @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
